// File: rtl/data_table_ram_ctrl.sv
// data_table_ram_ctrl: sequencer/arbiter in front of the data_table_ram
// simple-dual-port table. Clears the table after reset or on request, passes
// one writer straight through to the write port, round-robins two readers onto
// the single read port and returns tagged responses with write-first bypass.
module data_table_ram_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 9,
  parameter int unsigned           DATA_WIDTH = 38,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  // Clear control
  input  logic                  clr_req,
  output logic                  init_busy,

  // Writer
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,

  // Reader 0
  input  logic                  rd0_req,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic                  rd0_gnt,

  // Reader 1
  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_gnt,

  // Tagged read response
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,

  // RAM side
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic                  byp_q, byp_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

  logic in_run;
  logic rd_gnt_any;
  logic collide;

  assign in_run = (state_q == ST_RUN);

  // Round-robin read grant; rr_ptr only breaks ties when both readers request
  always_comb begin
    rd0_gnt = 1'b0;
    rd1_gnt = 1'b0;
    if (in_run) begin
      case ({rd1_req, rd0_req})
        2'b01:   rd0_gnt = 1'b1;
        2'b10:   rd1_gnt = 1'b1;
        2'b11: begin
          if (rr_ptr_q) begin
            rd1_gnt = 1'b1;
          end else begin
            rd0_gnt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_gnt_any  = rd0_gnt | rd1_gnt;
  // With no grant the read address defaults to reader 0; the RAM output is ignored
  assign ram_rd_addr = rd1_gnt ? rd1_addr : rd0_addr;

  assign wr_ack    = in_run & wr_req;
  assign init_busy = ~in_run;

  // Write port mux: clear sweep while initialising, writer pass-through otherwise
  always_comb begin
    if (in_run) begin
      ram_wr_en   = wr_req;
      ram_wr_addr = wr_addr;
      ram_wr_data = wr_data;
    end else begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = clr_cnt_q;
      ram_wr_data = INIT_VAL;
    end
  end

  // A read landing on the address being written this cycle must see the new word
  assign collide = rd_gnt_any & wr_ack & (ram_rd_addr == wr_addr);

  // Next-state: clear sequencing and run-mode transitions
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (in_run) begin
      clr_cnt_d = '0;
      if (clr_req) begin
        state_d = ST_INIT;
      end
    end else begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == CLR_LAST) begin
        state_d = ST_RUN;
      end
    end
  end

  // Next-state: arbiter pointer, response tag and bypass capture
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rd_gnt_any;
    rsp_id_d    = rsp_id_q;
    byp_d       = collide;
    byp_data_d  = byp_data_q;
    if (rd_gnt_any) begin
      rr_ptr_d = ~rd1_gnt;
      rsp_id_d = rd1_gnt;
    end
    if (collide) begin
      byp_data_d = wr_data;
    end
  end

  // State registers; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      rr_ptr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      byp_q       <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      byp_q       <= byp_d;
      byp_data_q  <= byp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  // RAM data arrives one cycle after the grant, aligned with rsp_valid
  assign rsp_data  = byp_q ? byp_data_q : ram_rd_data;

endmodule

// File: tb/tb_data_table_ram_ctrl.sv
// Testbench for data_table_ram_ctrl: behavioural RAM, reference table and a
// response scoreboard fed at stimulus time and drained by a response monitor.
module tb_data_table_ram_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 38;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_req;
  logic          init_busy;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd0_req;
  logic [AW-1:0] rd0_addr;
  logic          rd0_gnt;
  logic          rd1_req;
  logic [AW-1:0] rd1_addr;
  logic          rd1_gnt;
  logic          rsp_valid;
  logic          rsp_id;
  logic [DW-1:0] rsp_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  always #5 clk = ~clk;

  data_table_ram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INIT_VAL   ('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_req     (clr_req),
    .init_busy   (init_busy),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .rd0_req     (rd0_req),
    .rd0_addr    (rd0_addr),
    .rd0_gnt     (rd0_gnt),
    .rd1_req     (rd1_req),
    .rd1_addr    (rd1_addr),
    .rd1_gnt     (rd1_gnt),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  // Behavioural table: 1-cycle read, old data on same-address write
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  bit            rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      chk("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e[DW]));
        chk("rsp_data", 64'(rsp_data), 64'(e[DW-1:0]));
      end
    end
  end

  // One clock cycle of stimulus; run says whether the DUT should be in RUN
  task automatic step(input bit clr, input bit r0, input logic [AW-1:0] a0,
                      input bit r1, input logic [AW-1:0] a1,
                      input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit run, input int cidx);
    bit            e0, e1;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    clr_req  = clr;
    rd0_req  = r0;
    rd0_addr = a0;
    rd1_req  = r1;
    rd1_addr = a1;
    wr_req   = w;
    wr_addr  = wa;
    wr_data  = wd;
    e0 = 1'b0;
    e1 = 1'b0;
    ra = '0;
    if (run) begin
      e0 = r0 && (!r1 || !rr);
      e1 = r1 && (!r0 || rr);
    end
    if (e0 || e1) begin
      ra = e1 ? a1 : a0;
      rd = (w && wa == ra) ? wd : ref_mem[ra];
      exp_q.push_back({e1, rd});
      rr = e0;
    end
    if (run && w) ref_mem[wa] = wd;
    if (run && clr) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end
    @(negedge clk);
    chk("init_busy", 64'(init_busy), 64'(!run));
    chk("rd0_gnt", 64'(rd0_gnt), 64'(e0));
    chk("rd1_gnt", 64'(rd1_gnt), 64'(e1));
    chk("wr_ack", 64'(wr_ack), 64'(run && w));
    if (e0 || e1) chk("ram_rd_addr", 64'(ram_rd_addr), 64'(ra));
    if (run) begin
      chk("ram_wr_en", 64'(ram_wr_en), 64'(w));
      if (w) begin
        chk("ram_wr_addr", 64'(ram_wr_addr), 64'(wa));
        chk("ram_wr_data", 64'(ram_wr_data), 64'(wd));
      end
    end else begin
      chk("clr_wr_en", 64'(ram_wr_en), 64'd1);
      chk("clr_wr_addr", 64'(ram_wr_addr), 64'(cidx));
      chk("clr_wr_data", 64'(ram_wr_data), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 0);
  endtask

  // Clear sweep; noisy mode holds every request (and toggles clr_req) to prove they are ignored
  task automatic clear_sweep(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      step(noisy && i[0], noisy, AW'(i), noisy, AW'(i + 1), noisy, AW'(i), DW'(i + 1), 1'b0, i);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 64'(init_busy), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_wr_addr"}, 64'(ram_wr_addr), 64'd0);
    chk({tag, "_gnt"}, 64'({rd1_gnt, rd0_gnt}), 64'd0);
    chk({tag, "_wr_ack"}, 64'(wr_ack), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    clr_req  = 1'b0;
    wr_req   = 1'b1;
    wr_addr  = '0;
    wr_data  = '0;
    rd0_req  = 1'b1;
    rd0_addr = '0;
    rd1_req  = 1'b1;
    rd1_addr = '0;
    rr       = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state with requests held
    repeat (3) @(negedge clk);
    reset_checks("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Power-up clear: exactly 512 cycles, no grants or acks
    clear_sweep(DEPTH, 1'b1);

    // Write then read the same address
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 9'd5, 38'h15, 1'b1, 0);
    step(1'b0, 1'b1, 9'd5, 1'b0, '0, 1'b0, '0, '0, 1'b1, 0);
    idle();

    // Same-cycle write and read of addr 7 by reader 1: bypass
    step(1'b0, 1'b0, '0, 1'b1, 9'd7, 1'b1, 9'd7, 38'h2A, 1'b1, 0);
    idle();
    // Reread from the table, and a read alongside a write elsewhere
    step(1'b0, 1'b1, 9'd7, 1'b0, '0, 1'b1, 9'd9, 38'h33, 1'b1, 0);
    step(1'b0, 1'b0, '0, 1'b1, 9'd9, 1'b0, '0, '0, 1'b1, 0);

    // Both readers held six cycles: alternating grants, back-to-back responses
    repeat (6) step(1'b0, 1'b1, 9'd5, 1'b1, 9'd7, 1'b0, '0, '0, 1'b1, 0);
    idle();

    // Clear during traffic: the clr_req cycle is still served
    step(1'b0, 1'b1, 9'd9, 1'b1, 9'd7, 1'b1, 9'd3, 38'h3F_FFFF_FFFF, 1'b1, 0);
    step(1'b1, 1'b1, 9'd5, 1'b1, 9'd3, 1'b1, 9'd3, 38'h77, 1'b1, 0);
    clear_sweep(DEPTH, 1'b0);
    step(1'b0, 1'b1, 9'd5, 1'b0, '0, 1'b0, '0, '0, 1'b1, 0);
    step(1'b0, 1'b0, '0, 1'b1, 9'd7, 1'b0, '0, '0, 1'b1, 0);
    step(1'b0, 1'b1, 9'd3, 1'b0, '0, 1'b0, '0, '0, 1'b1, 0);

    // Reset with a response in flight: response dropped
    step(1'b0, 1'b0, '0, 1'b1, 9'd9, 1'b1, 9'd9, 38'h1234, 1'b1, 0);
    chk("inflight_valid", 64'(rsp_valid), 64'd1);
    void'(exp_q.pop_front());
    rst_n = 1'b0;
    rr    = 1'b0;
    #1;
    reset_checks("inflight_rst");
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset in the middle of a clear at address 100
    clear_sweep(100, 1'b0);
    chk("pre_rst_clr_addr", 64'(ram_wr_addr), 64'd100);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_clear_rst");
    @(posedge clk);
    #1;
    chk("held_rst_clr_addr", 64'(ram_wr_addr), 64'd0);
    rst_n = 1'b1;
    clear_sweep(DEPTH, 1'b0);

    // Pointer is back to reader 0 after reset; table is clear
    step(1'b0, 1'b1, 9'd9, 1'b1, 9'd5, 1'b0, '0, '0, 1'b1, 0);
    step(1'b0, 1'b1, 9'd9, 1'b1, 9'd5, 1'b0, '0, '0, 1'b1, 0);
    idle();
    idle();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
